// File: rtl/font_rom_8x16_if.sv
`default_nettype none
// ============================================================================
//  Module   : font_rom_8x16_if
//  Brief    : Address/row-bitmap bus between text control and the glyph ROM.
//  Revision : 1.0  initial release
// ============================================================================
interface font_rom_8x16_if;
    logic [10:0] addr;   // {ASCII code[6:0], glyph row[3:0]}
    logic [7:0]  data;   // row bitmap, bit 7 = leftmost pixel

    modport master (output addr, input  data);
    modport slave  (input  addr, output data);
endinterface
`default_nettype wire

// File: rtl/font_rom_8x16.sv
`default_nettype none
// ============================================================================
//  Module   : font_rom_8x16
//  Brief    : 8x16 CP437-style character ROM; registered address, 1-cycle
//             latency. Define FONT_ROM_OUTREG_EN to add an output register
//             (2-cycle latency).
//  Revision : 1.0  initial release
// ============================================================================
module font_rom_8x16 (
    input  logic           clk,
    input  logic           rst_n,
    font_rom_8x16_if.slave bus
);

    // Each glyph is 16 rows of 8 bits, row 0 in the top byte.
    localparam logic [127:0] c_glyph_heart  = 128'h0000_0000_6CFE_FEFE_FE7C_3810_0000_0000;
    localparam logic [127:0] c_glyph_marker = 128'h0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000;
    localparam logic [127:0] c_glyph_0      = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
    localparam logic [127:0] c_glyph_1      = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
    localparam logic [127:0] c_glyph_2      = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
    localparam logic [127:0] c_glyph_3      = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
    localparam logic [127:0] c_glyph_4      = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
    localparam logic [127:0] c_glyph_5      = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
    localparam logic [127:0] c_glyph_6      = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
    localparam logic [127:0] c_glyph_7      = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
    localparam logic [127:0] c_glyph_8      = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
    localparam logic [127:0] c_glyph_9      = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
    localparam logic [127:0] c_glyph_colon  = 128'h0000_0000_1818_0000_0018_1800_0000_0000;
    localparam logic [127:0] c_glyph_b      = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;
    localparam logic [127:0] c_glyph_c      = 128'h0000_3C66_C2C0_C0C0_C0C2_663C_0000_0000;
    localparam logic [127:0] c_glyph_e      = 128'h0000_FE66_6268_7868_6062_66FE_0000_0000;
    localparam logic [127:0] c_glyph_i      = 128'h0000_3C18_1818_1818_1818_183C_0000_0000;
    localparam logic [127:0] c_glyph_l      = 128'h0000_F060_6060_6060_6062_66FE_0000_0000;
    localparam logic [127:0] c_glyph_o      = 128'h0000_7CC6_C6C6_C6C6_C6C6_C67C_0000_0000;
    localparam logic [127:0] c_glyph_r      = 128'h0000_FC66_6666_7C6C_6666_66E6_0000_0000;
    localparam logic [127:0] c_glyph_s      = 128'h0000_7CC6_C660_380C_06C6_C67C_0000_0000;
    localparam logic [127:0] c_glyph_v      = 128'h0000_C6C6_C6C6_C6C6_C66C_3810_0000_0000;

    logic [10:0]  addr_d;
    logic [10:0]  addr_q;
    logic [127:0] w_glyph;
    logic [6:0]   w_bitpos;
    logic [7:0]   row_bits_d;

    assign addr_d = bus.addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    always_comb begin
        w_glyph = '0;
        case (addr_q[10:4])
            7'h03:   w_glyph = c_glyph_heart;
            7'h15:   w_glyph = c_glyph_marker;
            7'h30:   w_glyph = c_glyph_0;
            7'h31:   w_glyph = c_glyph_1;
            7'h32:   w_glyph = c_glyph_2;
            7'h33:   w_glyph = c_glyph_3;
            7'h34:   w_glyph = c_glyph_4;
            7'h35:   w_glyph = c_glyph_5;
            7'h36:   w_glyph = c_glyph_6;
            7'h37:   w_glyph = c_glyph_7;
            7'h38:   w_glyph = c_glyph_8;
            7'h39:   w_glyph = c_glyph_9;
            7'h3A:   w_glyph = c_glyph_colon;
            7'h42:   w_glyph = c_glyph_b;
            7'h43:   w_glyph = c_glyph_c;
            7'h45:   w_glyph = c_glyph_e;
            7'h49:   w_glyph = c_glyph_i;
            7'h4C:   w_glyph = c_glyph_l;
            7'h4F:   w_glyph = c_glyph_o;
            7'h52:   w_glyph = c_glyph_r;
            7'h53:   w_glyph = c_glyph_s;
            7'h56:   w_glyph = c_glyph_v;
            default: w_glyph = '0;
        endcase
    end

    // Row r occupies bits [127-8r -: 8].
    assign w_bitpos   = 7'd127 - {addr_q[3:0], 3'b000};
    assign row_bits_d = w_glyph[w_bitpos -: 8];

`ifdef FONT_ROM_OUTREG_EN
    logic [7:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= row_bits_d;
        end
    end

    assign bus.data = data_q;
`else
    assign bus.data = row_bits_d;
`endif

endmodule
`default_nettype wire

// File: tb/tb_font_rom_8x16.sv
`timescale 1ns/1ps
// Randomized + directed scoreboard bench for font_rom_8x16 (both latency builds).
module tb_font_rom_8x16;

`ifdef FONT_ROM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    font_rom_8x16_if bus ();

    font_rom_8x16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [10:0] addr;
        logic [7:0]  exp;
    } item_t;

    item_t       sb[$];
    item_t       mon_it;
    int          cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;
    logic [7:0]  font [128][16];
    logic [6:0]  populated [23] = '{7'h00, 7'h03, 7'h15, 7'h30, 7'h31, 7'h32, 7'h33, 7'h34,
                                    7'h35, 7'h36, 7'h37, 7'h38, 7'h39, 7'h3A, 7'h42, 7'h43,
                                    7'h45, 7'h49, 7'h4C, 7'h4F, 7'h52, 7'h53, 7'h56};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [10:0] a,
                         input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s addr=0x%03h got=0x%02h expected=0x%02h", name, a, act, exp);
        end
    endtask

    task automatic set_glyph(input int code, input logic [127:0] bits);
        for (int r = 0; r < 16; r++) font[code][r] = bits[127 - 8*r -: 8];
    endtask

    function automatic logic [7:0] model(input logic [10:0] a);
        return font[a[10:4]][a[3:0]];
    endfunction

    task automatic drive(input logic [10:0] a);
        item_t it;
        @(negedge clk);
        bus.addr = a;
        it.due  = cyc + LAT;
        it.addr = a;
        it.exp  = model(a);
        sb.push_back(it);
    endtask

    task automatic sweep(input logic [6:0] code);
        for (int r = 0; r < 16; r++) drive({code, 4'(r)});
    endtask

    // Monitor: compare every response whose latency has elapsed.
    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                mon_it = sb.pop_front();
                check("lookup", mon_it.addr, bus.data, mon_it.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] code;
        logic [3:0] row;

        for (int c = 0; c < 128; c++)
            for (int r = 0; r < 16; r++) font[c][r] = 8'h00;
        set_glyph(8'h03, 128'h0000_0000_6CFE_FEFE_FE7C_3810_0000_0000);
        set_glyph(8'h30, 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000);
        set_glyph(8'h31, 128'h0000_1838_7818_1818_1818_187E_0000_0000);
        set_glyph(8'h32, 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000);
        set_glyph(8'h33, 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000);
        set_glyph(8'h34, 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000);
        set_glyph(8'h35, 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000);
        set_glyph(8'h36, 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000);
        set_glyph(8'h37, 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000);
        set_glyph(8'h38, 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000);
        set_glyph(8'h39, 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000);
        set_glyph(8'h3A, 128'h0000_0000_1818_0000_0018_1800_0000_0000);
        set_glyph(8'h42, 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000);
        set_glyph(8'h43, 128'h0000_3C66_C2C0_C0C0_C0C2_663C_0000_0000);
        set_glyph(8'h45, 128'h0000_FE66_6268_7868_6062_66FE_0000_0000);
        set_glyph(8'h49, 128'h0000_3C18_1818_1818_1818_183C_0000_0000);
        set_glyph(8'h4C, 128'h0000_F060_6060_6060_6062_66FE_0000_0000);
        set_glyph(8'h4F, 128'h0000_7CC6_C6C6_C6C6_C6C6_C67C_0000_0000);
        set_glyph(8'h52, 128'h0000_FC66_6666_7C6C_6666_66E6_0000_0000);
        set_glyph(8'h53, 128'h0000_7CC6_C660_380C_06C6_C67C_0000_0000);
        set_glyph(8'h56, 128'h0000_C6C6_C6C6_C6C6_C66C_3810_0000_0000);
        for (int r = 0; r < 16; r++) font[8'h15][r] = (r >= 2 && r <= 13) ? 8'hFF : 8'h00;

        // Reset held with a live address: output must stay blank.
        bus.addr = 11'h305;
        rst_n    = 1'b0;
        #1 check("reset_hold", bus.addr, bus.data, 8'h00);
        repeat (3) @(posedge clk);
        #1 check("reset_hold_clk", bus.addr, bus.data, 8'h00);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        drive(11'h305);
        sweep(7'h30);
        sweep(7'h03);
        sweep(7'h42);
        sweep(7'h3A);
        sweep(7'h15);
        sweep(7'h41);
        sweep(7'h7F);
        drive(11'h313);

        // Reset asserted between edges in the middle of a sweep.
        for (int r = 0; r < 8; r++) drive({7'h30, 4'(r)});
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        #1 check("reset_async", bus.addr, bus.data, 8'h00);
        sb.delete();
        @(posedge clk);
        #1 check("reset_async_clk", bus.addr, bus.data, 8'h00);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        repeat (400) begin
            if ($urandom_range(0, 1) == 1) code = populated[$urandom_range(0, 22)];
            else                           code = 7'($urandom_range(0, 127));
            row = 4'($urandom_range(0, 15));
            drive({code, row});
        end

        for (int i = 0; i < LAT + 5 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
